tl_txn_tracker: RTL and testbench

- Synthesizable TileLink A/D transaction tracker.
- Taps the same tile master-port signals the tile monitor logs, passively, without driving ready/valid.
- Pairs each A request with its D response by source ID.
- Measures latency, counts traffic, and raises error pulses for duplicate source, orphan response, denied/corrupt response and timeout. The bench and the v2c status path consume these outputs.

---
 rtl/tl_trk_pkg.sv | 53 +++++
 rtl/tl_txn_tracker_beat.sv | 31 +++
 rtl/tl_txn_tracker.sv | 200 ++++++++++++++++++++
 tb/tb_tl_txn_tracker.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_trk_pkg.sv
// Shared types and helpers for the TileLink transaction tracker.
// Opcodes, error codes, beat math and the per-source table entry.
package tl_trk_pkg;

  localparam logic [2:0] A_PUT_FULL  = 3'd0;
  localparam logic [2:0] A_PUT_PART  = 3'd1;
  localparam logic [2:0] A_ARITH     = 3'd2;
  localparam logic [2:0] A_LOGICAL   = 3'd3;
  localparam logic [2:0] A_GET       = 3'd4;
  localparam logic [2:0] A_INTENT    = 3'd5;

  localparam logic [2:0] D_ACK       = 3'd0;
  localparam logic [2:0] D_ACK_DATA  = 3'd1;
  localparam logic [2:0] D_HINT_ACK  = 3'd2;
  localparam logic [2:0] D_GRANT     = 3'd4;
  localparam logic [2:0] D_GRANT_DATA = 3'd5;

  // size is 4 bits, so a burst has at most 2**12 beats
  localparam int BEAT_W = 13;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_DUP     = 3'd1,
    ERR_ORPHAN  = 3'd2,
    ERR_TIMEOUT = 3'd3,
    ERR_DENIED  = 3'd4
  } err_code_e;

  typedef struct packed {
    logic        valid;
    logic        timed_out;
    logic [31:0] address;
    logic [31:0] age;
  } entry_t;

  function automatic logic a_has_data(input logic [2:0] op);
    return op inside {A_PUT_FULL, A_PUT_PART, A_ARITH, A_LOGICAL};
  endfunction

  function automatic logic d_has_data(input logic [2:0] op);
    return op inside {D_ACK_DATA, D_GRANT_DATA};
  endfunction

  function automatic logic [BEAT_W-1:0] tl_beats(
    input logic [3:0] size,
    input logic       data
  );
    if (data && size > 4'd3)
      return BEAT_W'(1) << (size - 4'd3);
    return BEAT_W'(1);
  endfunction

endpackage

// File: rtl/tl_txn_tracker_beat.sv
// Burst position counter for one TileLink channel.
// Flags either the first or the last beat of each message.
module tl_beat_counter
  import tl_trk_pkg::*;
#(
  parameter bit LAST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              fire,
  input  logic [BEAT_W-1:0] beats,
  output logic              hit
);

  logic [BEAT_W-1:0] cnt;
  logic              at_first;
  logic              at_last;

  assign at_first = (cnt == '0);
  assign at_last  = (cnt == beats - BEAT_W'(1));
  assign hit      = fire && (LAST ? at_last : at_first);

  always_ff @(posedge clk) begin
    if (!rst_n || clear)
      cnt <= '0;
    else if (fire)
      cnt <= at_last ? '0 : cnt + BEAT_W'(1);
  end

endmodule

// File: rtl/tl_txn_tracker.sv
// Passive TileLink A/D tracker: pairs requests with responses by
// source, measures latency, counts traffic and flags protocol errors.
module tl_txn_tracker
  import tl_trk_pkg::*;
#(
  parameter int SRC_W   = 2,
  parameter int TIMEOUT = 1024,
  parameter int LAT_W   = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             a_ready,
  input  logic             a_valid,
  input  logic [2:0]       a_bits_opcode,
  input  logic [3:0]       a_bits_size,
  input  logic [SRC_W-1:0] a_bits_source,
  input  logic [31:0]      a_bits_address,
  input  logic             d_ready,
  input  logic             d_valid,
  input  logic [2:0]       d_bits_opcode,
  input  logic [3:0]       d_bits_size,
  input  logic [SRC_W-1:0] d_bits_source,
  input  logic             d_bits_denied,
  input  logic             d_bits_corrupt,
  output logic [SRC_W:0]   outstanding,
  output logic [CNT_W-1:0] req_count,
  output logic [CNT_W-1:0] resp_count,
  output logic [LAT_W-1:0] last_latency,
  output logic [LAT_W-1:0] max_latency,
  output logic             err_valid,
  output logic [2:0]       err_code,
  output logic [SRC_W-1:0] err_source,
  output logic [31:0]      err_address,
  output logic             err_overflow
);

  localparam int N = 2 ** SRC_W;
  localparam logic [31:0] AGE_MAX =
    32'((64'd1 << LAT_W) - 64'd1);
  localparam logic [31:0] TO_LIM = 32'(TIMEOUT - 1);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v >= AGE_MAX) ? AGE_MAX : v + 32'd1;
  endfunction

  entry_t tbl    [N];
  entry_t tbl_nx [N];

  logic              a_fire, d_fire;
  logic              a_first, d_last;
  logic [BEAT_W-1:0] a_beats, d_beats;

  assign a_fire  = a_valid & a_ready & enable;
  assign d_fire  = d_valid & d_ready & enable;
  assign a_beats = tl_beats(a_bits_size, a_has_data(a_bits_opcode));
  assign d_beats = tl_beats(d_bits_size, d_has_data(d_bits_opcode));

  tl_beat_counter #(.LAST(1'b0)) u_a_beat (
    .clk   (clock),
    .rst_n (reset),
    .clear (clear),
    .fire  (a_fire),
    .beats (a_beats),
    .hit   (a_first)
  );

  tl_beat_counter #(.LAST(1'b1)) u_d_beat (
    .clk   (clock),
    .rst_n (reset),
    .clear (clear),
    .fire  (d_fire),
    .beats (d_beats),
    .hit   (d_last)
  );

  entry_t           a_ent, d_ent;
  logic             hit, orphan, dup, deny;
  logic [LAT_W-1:0] d_lat;

  assign a_ent  = tbl[a_bits_source];
  assign d_ent  = tbl[d_bits_source];
  assign hit    = d_last & d_ent.valid;
  assign orphan = d_last & ~d_ent.valid;
  // a retire on the same source frees the slot before the alloc
  assign dup    = a_first & a_ent.valid
                & ~(hit & (d_bits_source == a_bits_source));
  assign deny   = hit & (d_bits_denied | d_bits_corrupt);
  assign d_lat  = LAT_W'(sat_inc(d_ent.age));

  logic [N-1:0]     tmo;
  logic             to_any;
  logic [SRC_W-1:0] to_src;
  logic [SRC_W:0]   nx_out;

  always_comb begin
    tmo    = '0;
    to_any = 1'b0;
    to_src = '0;
    nx_out = '0;
    for (int i = 0; i < N; i++) begin
      tmo[i] = enable & tbl[i].valid & ~tbl[i].timed_out
             & (sat_inc(tbl[i].age) >= TO_LIM);
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (tmo[i]) begin
        to_any = 1'b1;
        to_src = SRC_W'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      tbl_nx[i] = tbl[i];
      if (enable && tbl[i].valid)
        tbl_nx[i].age = sat_inc(tbl[i].age);
      if (tmo[i])
        tbl_nx[i].timed_out = 1'b1;
    end
    if (hit)
      tbl_nx[d_bits_source].valid = 1'b0;
    if (a_first) begin
      tbl_nx[a_bits_source].valid     = 1'b1;
      tbl_nx[a_bits_source].timed_out = 1'b0;
      tbl_nx[a_bits_source].address   = a_bits_address;
      tbl_nx[a_bits_source].age       = '0;
    end
    for (int i = 0; i < N; i++)
      nx_out = nx_out + (SRC_W + 1)'(tbl_nx[i].valid);
  end

  err_code_e        w_code;
  logic [SRC_W-1:0] w_src;
  logic [31:0]      w_addr;
  logic [2:0]       n_kind;
  logic             multi;

  always_comb begin
    w_code = ERR_NONE;
    w_src  = '0;
    w_addr = '0;
    if (orphan) begin
      w_code = ERR_ORPHAN;
      w_src  = d_bits_source;
    end else if (dup) begin
      w_code = ERR_DUP;
      w_src  = a_bits_source;
      w_addr = a_ent.address;
    end else if (deny) begin
      w_code = ERR_DENIED;
      w_src  = d_bits_source;
      w_addr = d_ent.address;
    end else if (to_any) begin
      w_code = ERR_TIMEOUT;
      w_src  = to_src;
      w_addr = tbl[to_src].address;
    end
  end

  assign n_kind = {2'b0, orphan} + {2'b0, dup}
                + {2'b0, deny} + {2'b0, to_any};
  assign multi  = (n_kind > 3'd1)
                | ((tmo & (tmo - N'(1))) != '0);

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      for (int i = 0; i < N; i++)
        tbl[i] <= '0;
      outstanding  <= '0;
      req_count    <= '0;
      resp_count   <= '0;
      last_latency <= '0;
      max_latency  <= '0;
      err_valid    <= 1'b0;
      err_code     <= '0;
      err_source   <= '0;
      err_address  <= '0;
      err_overflow <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++)
        tbl[i] <= tbl_nx[i];
      outstanding <= nx_out;
      if (a_first)
        req_count <= req_count + CNT_W'(1);
      if (hit) begin
        resp_count   <= resp_count + CNT_W'(1);
        last_latency <= d_lat;
        if (d_lat > max_latency)
          max_latency <= d_lat;
      end
      err_valid   <= (w_code != ERR_NONE);
      err_code    <= w_code;
      err_source  <= w_src;
      err_address <= w_addr;
      if (multi)
        err_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tl_txn_tracker.sv
// Randomized and directed bench for tl_txn_tracker against a
// timestamp-based transaction model.
module tb_tl_txn_tracker;

  localparam int SRC_W   = 2;
  localparam int N       = 4;
  localparam int TIMEOUT = 16;
  localparam int LAT_W   = 16;
  localparam int CNT_W   = 6;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic clear = 1'b0;
  logic a_ready = 1'b0, a_valid = 1'b0;
  logic [2:0] a_bits_opcode = '0;
  logic [3:0] a_bits_size = '0;
  logic [SRC_W-1:0] a_bits_source = '0;
  logic [31:0] a_bits_address = '0;
  logic d_ready = 1'b0, d_valid = 1'b0;
  logic [2:0] d_bits_opcode = '0;
  logic [3:0] d_bits_size = '0;
  logic [SRC_W-1:0] d_bits_source = '0;
  logic d_bits_denied = 1'b0, d_bits_corrupt = 1'b0;
  logic [SRC_W:0] outstanding;
  logic [CNT_W-1:0] req_count, resp_count;
  logic [LAT_W-1:0] last_latency, max_latency;
  logic err_valid, err_overflow;
  logic [2:0] err_code;
  logic [SRC_W-1:0] err_source;
  logic [31:0] err_address;

  always #5 clock = ~clock;

  tl_txn_tracker #(
    .SRC_W(SRC_W), .TIMEOUT(TIMEOUT),
    .LAT_W(LAT_W), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset),
    .enable(enable), .clear(clear),
    .a_ready(a_ready), .a_valid(a_valid),
    .a_bits_opcode(a_bits_opcode),
    .a_bits_size(a_bits_size),
    .a_bits_source(a_bits_source),
    .a_bits_address(a_bits_address),
    .d_ready(d_ready), .d_valid(d_valid),
    .d_bits_opcode(d_bits_opcode),
    .d_bits_size(d_bits_size),
    .d_bits_source(d_bits_source),
    .d_bits_denied(d_bits_denied),
    .d_bits_corrupt(d_bits_corrupt),
    .outstanding(outstanding),
    .req_count(req_count), .resp_count(resp_count),
    .last_latency(last_latency),
    .max_latency(max_latency),
    .err_valid(err_valid), .err_code(err_code),
    .err_source(err_source),
    .err_address(err_address),
    .err_overflow(err_overflow)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // model: timestamps in enabled cycles, beats left per channel
  bit          m_v  [N];
  bit          m_to [N];
  logic [31:0] m_addr [N];
  longint      m_stamp [N];
  longint      now = 0;
  int a_left = 0, d_left = 0;
  int m_req = 0, m_resp = 0, m_last = 0, m_max = 0;
  bit e_valid = 0, e_ovf = 0;
  int e_code = 0, e_src = 0;
  logic [31:0] e_addr = '0;

  function automatic int beats(input int op, input int sz,
                               input bit is_a);
    bit data;
    data = is_a ? (op <= 3) : (op == 1 || op == 5);
    return (data && sz > 3) ? (1 << (sz - 3)) : 1;
  endfunction

  function automatic int lat_of(input int i);
    longint l;
    l = now - m_stamp[i];
    return (l > 65535) ? 65535 : int'(l);
  endfunction

  task automatic step();
    bit afirst, dlast, hit, orph, dup, den;
    int as, ds, n, tsrc, lat, pc;
    as = int'(a_bits_source);
    ds = int'(d_bits_source);
    e_valid = 0;
    if (!reset || clear) begin
      for (int i = 0; i < N; i++) begin
        m_v[i] = 0;
        m_to[i] = 0;
      end
      a_left = 0; d_left = 0;
      m_req = 0; m_resp = 0; m_last = 0; m_max = 0;
      e_ovf = 0;
    end else begin
      afirst = 0;
      dlast = 0;
      if (a_valid && a_ready && enable) begin
        if (a_left == 0) begin
          afirst = 1;
          a_left = beats(a_bits_opcode, a_bits_size, 1);
        end
        a_left--;
      end
      if (d_valid && d_ready && enable) begin
        if (d_left == 0)
          d_left = beats(d_bits_opcode, d_bits_size, 0);
        d_left--;
        dlast = (d_left == 0);
      end
      hit  = dlast && m_v[ds];
      orph = dlast && !m_v[ds];
      dup  = afirst && m_v[as] && !(hit && ds == as);
      den  = hit && (d_bits_denied || d_bits_corrupt);
      n = int'(orph) + int'(dup) + int'(den);
      tsrc = -1;
      if (enable) begin
        for (int i = 0; i < N; i++) begin
          if (m_v[i] && !m_to[i] && lat_of(i) >= TIMEOUT - 1) begin
            n++;
            if (tsrc < 0) tsrc = i;
            m_to[i] = 1;
          end
        end
      end
      if (n > 1) e_ovf = 1;
      e_valid = (n > 0);
      if (orph) begin
        e_code = 2; e_src = ds; e_addr = '0;
      end else if (dup) begin
        e_code = 1; e_src = as; e_addr = m_addr[as];
      end else if (den) begin
        e_code = 4; e_src = ds; e_addr = m_addr[ds];
      end else if (tsrc >= 0) begin
        e_code = 3; e_src = tsrc; e_addr = m_addr[tsrc];
      end
      if (hit) begin
        lat = lat_of(ds);
        m_last = lat;
        if (lat > m_max) m_max = lat;
        m_v[ds] = 0;
        m_resp++;
      end
      if (afirst) begin
        m_v[as] = 1;
        m_to[as] = 0;
        m_addr[as] = a_bits_address;
        m_stamp[as] = now;
        m_req++;
      end
      if (enable) now++;
    end
    @(posedge clock);
    #1;
    pc = 0;
    for (int i = 0; i < N; i++) pc += int'(m_v[i]);
    check("outstanding", 64'(outstanding), 64'(pc));
    check("req_count", 64'(req_count), 64'(m_req % 64));
    check("resp_count", 64'(resp_count), 64'(m_resp % 64));
    check("last_latency", 64'(last_latency), 64'(m_last));
    check("max_latency", 64'(max_latency), 64'(m_max));
    check("err_valid", 64'(err_valid), 64'(e_valid));
    check("err_overflow", 64'(err_overflow), 64'(e_ovf));
    if (e_valid) begin
      check("err_code", 64'(err_code), 64'(e_code));
      check("err_source", 64'(err_source), 64'(e_src));
      check("err_address", 64'(err_address), 64'(e_addr));
    end
  endtask

  task automatic idle(input int n);
    a_valid = 0;
    d_valid = 0;
    repeat (n) step();
  endtask

  task automatic set_a(input int op, input int sz,
                       input int src, input logic [31:0] addr);
    a_valid = 1; a_ready = 1;
    a_bits_opcode = 3'(op); a_bits_size = 4'(sz);
    a_bits_source = SRC_W'(src); a_bits_address = addr;
  endtask

  task automatic set_d(input int op, input int sz,
                       input int src, input bit den);
    d_valid = 1; d_ready = 1;
    d_bits_opcode = 3'(op); d_bits_size = 4'(sz);
    d_bits_source = SRC_W'(src);
    d_bits_denied = den; d_bits_corrupt = 0;
  endtask

  task automatic a_msg(input int op, input int sz,
                       input int src, input logic [31:0] addr);
    set_a(op, sz, src, addr);
    step();
    a_valid = 0;
  endtask

  task automatic d_beat(input int op, input int sz,
                        input int src, input bit den);
    set_d(op, sz, src, den);
    step();
    d_valid = 0;
  endtask

  task automatic do_clear();
    clear = 1;
    idle(1);
    clear = 0;
  endtask

  int pulses, at, vs;

  initial begin
    reset = 0;
    idle(3);
    check("rst_code", 64'(err_code), 64'd0);
    check("rst_addr", 64'(err_address), 64'd0);
    reset = 1;
    enable = 1;
    idle(6);

    // simple Get / AccessAckData
    a_msg(4, 3, 1, 32'h8000_0000);
    check("get_out1", 64'(outstanding), 64'd1);
    idle(4);
    d_beat(1, 3, 1, 0);
    check("get_lat", 64'(last_latency), 64'd5);
    check("get_max", 64'(max_latency), 64'd5);
    check("get_req", 64'(req_count), 64'd1);
    check("get_resp", 64'(resp_count), 64'd1);
    check("get_out0", 64'(outstanding), 64'd0);
    check("get_noerr", 64'(err_valid), 64'd0);

    // burst retire on the 8th beat
    do_clear();
    a_msg(4, 6, 2, 32'h1000);
    idle(2);
    repeat (7) d_beat(1, 6, 2, 0);
    check("burst_mid", 64'(resp_count), 64'd0);
    d_beat(1, 6, 2, 0);
    check("burst_resp", 64'(resp_count), 64'd1);
    check("burst_lat", 64'(last_latency), 64'd10);

    // orphan then duplicate
    do_clear();
    d_beat(0, 0, 3, 0);
    check("orph_code", 64'(err_code), 64'd2);
    check("orph_src", 64'(err_source), 64'd3);
    check("orph_addr", 64'(err_address), 64'd0);
    a_msg(4, 0, 0, 32'h100);
    a_msg(4, 0, 0, 32'h200);
    check("dup_valid", 64'(err_valid), 64'd1);
    check("dup_code", 64'(err_code), 64'd1);
    check("dup_addr", 64'(err_address), 64'h100);

    // single timeout pulse
    do_clear();
    a_msg(4, 3, 0, 32'h2000);
    pulses = 0;
    at = 0;
    for (int k = 1; k <= 30; k++) begin
      idle(1);
      if (err_valid && err_code == 3'd3) begin
        pulses++;
        at = k;
      end
    end
    check("to_pulses", 64'(pulses), 64'd1);
    check("to_at", 64'(at), 64'd15);
    d_beat(0, 0, 0, 0);
    check("to_lat_ge16", 64'(last_latency >= 16), 64'd1);
    check("to_noerr", 64'(err_valid), 64'd0);

    // orphan and timeout collide
    do_clear();
    a_msg(4, 3, 0, 32'h3000);
    idle(14);
    d_beat(0, 0, 3, 0);
    check("col_code", 64'(err_code), 64'd2);
    check("col_ovf", 64'(err_overflow), 64'd1);

    // same-cycle retire and alloc on src 1
    do_clear();
    a_msg(4, 3, 1, 32'h40);
    idle(2);
    set_a(4, 3, 1, 32'h44);
    set_d(0, 0, 1, 0);
    step();
    a_valid = 0;
    d_valid = 0;
    check("ra_out", 64'(outstanding), 64'd1);
    check("ra_noerr", 64'(err_valid), 64'd0);

    // clear with 3 outstanding
    do_clear();
    a_msg(4, 0, 0, 32'h10);
    a_msg(4, 0, 1, 32'h20);
    a_msg(4, 0, 2, 32'h30);
    check("clr_pre", 64'(outstanding), 64'd3);
    do_clear();
    check("clr_out", 64'(outstanding), 64'd0);
    check("clr_req", 64'(req_count), 64'd0);
    d_beat(0, 0, 1, 0);
    check("clr_orph", 64'(err_code), 64'd2);

    // reset mid-burst
    a_msg(4, 6, 2, 32'h50);
    repeat (3) d_beat(1, 6, 2, 0);
    reset = 0;
    idle(1);
    reset = 1;
    check("rstb_req", 64'(req_count), 64'd0);
    d_beat(0, 0, 2, 0);
    check("rstb_orph", 64'(err_code), 64'd2);

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      reset  = ($urandom_range(0, 499) != 0);
      clear  = ($urandom_range(0, 299) == 0);
      enable = ($urandom_range(0, 9) != 0);
      a_ready = ($urandom_range(0, 3) != 0);
      d_ready = ($urandom_range(0, 3) != 0);
      a_valid = ($urandom_range(0, 2) == 0);
      d_valid = ($urandom_range(0, 1) == 0);
      if (a_left == 0) begin
        a_bits_opcode  = 3'($urandom_range(0, 7));
        a_bits_size    = 4'($urandom_range(0, 6));
        a_bits_source  = SRC_W'($urandom_range(0, N - 1));
        a_bits_address = $urandom;
      end
      if (d_left == 0) begin
        d_bits_opcode = 3'($urandom_range(0, 7));
        d_bits_size   = 4'($urandom_range(0, 6));
        vs = $urandom_range(0, N - 1);
        if ($urandom_range(0, 1) == 0) begin
          for (int i = 0; i < N; i++)
            if (m_v[i]) vs = i;
        end
        d_bits_source = SRC_W'(vs);
      end
      d_bits_denied  = ($urandom_range(0, 7) == 0);
      d_bits_corrupt = ($urandom_range(0, 7) == 0);
      step();
    end
    clear = 0;
    reset = 1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
